// File: rtl/rv_pkg.sv
// rv_pkg: RV32I field widths, opcodes and decoded-instruction record shared by decode and buffer
package rv_pkg;
  localparam int OPT_SIZE = 7;
  localparam int FUNCT_SIZE = 3;
  localparam int REG_SIZE = 5;
  localparam logic [OPT_SIZE-1:0] OP_R      = 7'b0110011;
  localparam logic [OPT_SIZE-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPT_SIZE-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPT_SIZE-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPT_SIZE-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPT_SIZE-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPT_SIZE-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPT_SIZE-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPT_SIZE-1:0] OP_JAL    = 7'b1101111;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;
  typedef struct packed {
    logic [OPT_SIZE-1:0]   opt;
    logic [FUNCT_SIZE-1:0] funct;
    logic [REG_SIZE-1:0]   rs1;
    logic [REG_SIZE-1:0]   rs2;
    logic [REG_SIZE-1:0]   rd;
    logic [31:0]           imm;
  } dec_t;
  function automatic fmt_e fmt_of(input logic [OPT_SIZE-1:0] opt);
    case (opt)
      OP_R: return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR: return FMT_I;
      OP_STORE: return FMT_S;
      OP_BRANCH: return FMT_B;
      OP_LUI, OP_AUIPC: return FMT_U;
      OP_JAL: return FMT_J;
      default: return FMT_X;
    endcase
  endfunction
endpackage

// File: rtl/i_decode_if.sv
// i_decode_if: fetch-side valid/ready and buffer-side decoded-instruction bundle
interface i_decode_if #(parameter int DATA_WIDTH = 32);
  import rv_pkg::*;
  logic                  if_valid;
  logic [31:0]           if_inst;
  logic                  if_ready;
  logic                  id_valid;
  logic                  ib_vacant;
  logic [OPT_SIZE-1:0]   id_opt;
  logic [FUNCT_SIZE-1:0] id_funct;
  logic [REG_SIZE-1:0]   id_rs1;
  logic [REG_SIZE-1:0]   id_rs2;
  logic [REG_SIZE-1:0]   id_rd;
  logic [DATA_WIDTH-1:0] id_imm;
  logic                  err_illegal;
  modport master (
    output if_valid, if_inst, ib_vacant,
    input  if_ready, id_valid, id_opt, id_funct, id_rs1, id_rs2, id_rd, id_imm, err_illegal
  );
  modport slave (
    input  if_valid, if_inst, ib_vacant,
    output if_ready, id_valid, id_opt, id_funct, id_rs1, id_rs2, id_rd, id_imm, err_illegal
  );
endinterface

// File: rtl/i_decode_fields.sv
// i_decode_fields: combinational split of an RV32I word into fields and 32-bit sign-extended immediate
module i_decode_fields
  import rv_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec,
  output logic        illegal
);
  fmt_e fmt;
  logic [31:0] imm;
  assign fmt = fmt_of(inst[6:0]);
  assign illegal = fmt == FMT_X;
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U: imm = {inst[31:12], 12'b0};
      FMT_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end
  assign dec.opt   = inst[6:0];
  assign dec.funct = (fmt == FMT_U || fmt == FMT_J) ? '0 : inst[14:12];
  assign dec.rs1   = (fmt == FMT_U || fmt == FMT_J) ? '0 : inst[19:15];
  assign dec.rs2   = (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B) ? inst[24:20] : '0;
  assign dec.rd    = (fmt == FMT_S || fmt == FMT_B) ? '0 : inst[11:7];
  assign dec.imm   = imm;
endmodule

// File: rtl/i_decode.sv
// i_decode: decode stage with registered output entry and one-entry skid so if_ready is a flop
module i_decode
  import rv_pkg::*;
#(parameter int DATA_WIDTH = 32)
(
  input logic      clk,
  input logic      rst,
  input logic      flush,
  i_decode_if.slave bus
);
  dec_t dec, main_q, skid_q, main_n, skid_n;
  logic illegal, main_v, skid_v, main_v_n, skid_v_n, ready_q, err_q;
  logic accept, take, main_free;
  i_decode_fields u_fields (.inst(bus.if_inst), .dec(dec), .illegal(illegal));
  assign accept = bus.if_valid && ready_q;
  assign take = accept && !illegal;
  assign main_free = !main_v || bus.ib_vacant;
  // Skid always drains into main first so program order holds
  always_comb begin
    main_v_n = main_v;
    skid_v_n = skid_v;
    main_n = main_q;
    skid_n = skid_q;
    if (flush) begin
      main_v_n = 1'b0;
      skid_v_n = 1'b0;
    end else if (main_free) begin
      main_v_n = skid_v || take;
      main_n = skid_v ? skid_q : take ? dec : main_q;
      skid_v_n = skid_v && take;
      skid_n = (skid_v && take) ? dec : skid_q;
    end else if (take) begin
      skid_v_n = 1'b1;
      skid_n = dec;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
      ready_q <= 1'b1;
      err_q <= 1'b0;
    end else begin
      main_v <= main_v_n;
      skid_v <= skid_v_n;
      main_q <= main_n;
      skid_q <= skid_n;
      ready_q <= !skid_v_n;
      err_q <= err_q || (accept && illegal && !flush);
    end
  assign bus.if_ready = ready_q;
  assign bus.id_valid = main_v;
  assign bus.id_opt = main_q.opt;
  assign bus.id_funct = main_q.funct;
  assign bus.id_rs1 = main_q.rs1;
  assign bus.id_rs2 = main_q.rs2;
  assign bus.id_rd = main_q.rd;
  assign bus.id_imm = DATA_WIDTH'(signed'(main_q.imm));
  assign bus.err_illegal = err_q;
endmodule

// File: tb/tb_i_decode.sv
// tb_i_decode: directed vectors for field decode, backpressure ordering, illegal drop and flush
module tb_i_decode;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int checks = 0;
  int failures = 0;
  i_decode_if #(.DATA_WIDTH(32)) bus ();
  i_decode #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [31:0] w);
    @(negedge clk);
    bus.if_valid = 1'b1;
    bus.if_inst = w;
    @(posedge clk);
    #1 bus.if_valid = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.if_valid = 1'b0;
    bus.if_inst = '0;
    bus.ib_vacant = 1'b1;
    #12;
    check("rst_valid", bus.id_valid, 0);
    check("rst_ready", bus.if_ready, 1);
    check("rst_err", bus.err_illegal, 0);
    check("rst_imm", bus.id_imm, 0);
    check("rst_rd", bus.id_rd, 0);
    rst = 1'b0;
    send(32'hFFB10093);
    check("addi_valid", bus.id_valid, 1);
    check("addi_opt", bus.id_opt, 7'b0010011);
    check("addi_funct", bus.id_funct, 0);
    check("addi_rs1", bus.id_rs1, 2);
    check("addi_rs2", bus.id_rs2, 0);
    check("addi_rd", bus.id_rd, 1);
    check("addi_imm", bus.id_imm, 32'hFFFFFFFB);
    send(32'h00532423);
    check("sw_valid", bus.id_valid, 1);
    check("sw_opt", bus.id_opt, 7'b0100011);
    check("sw_funct", bus.id_funct, 2);
    check("sw_rs1", bus.id_rs1, 6);
    check("sw_rs2", bus.id_rs2, 5);
    check("sw_rd", bus.id_rd, 0);
    check("sw_imm", bus.id_imm, 8);
    send(32'h123451B7);
    check("lui_imm", bus.id_imm, 32'h12345000);
    check("lui_rd", bus.id_rd, 3);
    check("lui_rs1", bus.id_rs1, 0);
    check("lui_rs2", bus.id_rs2, 0);
    check("lui_funct", bus.id_funct, 0);
    send(32'hFE000EE3);
    check("beq_imm", bus.id_imm, 32'hFFFFFFFC);
    check("beq_rd", bus.id_rd, 0);
    check("beq_opt", bus.id_opt, 7'b1100011);
    tick();
    check("drain_valid", bus.id_valid, 0);
    bus.ib_vacant = 1'b0;
    send(32'hFFB10093);
    check("bp1_ready", bus.if_ready, 1);
    check("bp1_imm", bus.id_imm, 32'hFFFFFFFB);
    send(32'h00532423);
    check("bp2_ready", bus.if_ready, 0);
    check("bp2_rd", bus.id_rd, 1);
    @(negedge clk);
    bus.if_valid = 1'b1;
    bus.if_inst = 32'h123451B7;
    @(posedge clk);
    #1;
    check("bp3_ready", bus.if_ready, 0);
    check("bp3_hold", bus.id_imm, 32'hFFFFFFFB);
    @(negedge clk);
    check("out1_imm", bus.id_imm, 32'hFFFFFFFB);
    bus.ib_vacant = 1'b1;
    tick();
    check("out2_valid", bus.id_valid, 1);
    check("out2_imm", bus.id_imm, 8);
    check("out2_ready", bus.if_ready, 1);
    tick();
    bus.if_valid = 1'b0;
    check("out3_valid", bus.id_valid, 1);
    check("out3_imm", bus.id_imm, 32'h12345000);
    tick();
    check("out_end_valid", bus.id_valid, 0);
    send(32'h00000000);
    check("ill_valid", bus.id_valid, 0);
    check("ill_err", bus.err_illegal, 1);
    bus.ib_vacant = 1'b0;
    send(32'hFFB10093);
    send(32'h00532423);
    check("full_ready", bus.if_ready, 0);
    check("full_valid", bus.id_valid, 1);
    @(negedge clk);
    flush = 1'b1;
    bus.if_valid = 1'b1;
    bus.if_inst = 32'h123451B7;
    @(posedge clk);
    #1 flush = 1'b0;
    bus.if_valid = 1'b0;
    check("fl_valid", bus.id_valid, 0);
    check("fl_ready", bus.if_ready, 1);
    check("fl_err", bus.err_illegal, 1);
    tick();
    check("fl_stay", bus.id_valid, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_err", bus.err_illegal, 0);
    check("arst_ready", bus.if_ready, 1);
    rst = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i_decode.md
Name: i_decode

Overview:
- Decode stage directly upstream of the instruction buffer (i_buffer).
- Accepts raw 32-bit RV32I instruction words from fetch through a valid/ready handshake and splits them into opt/funct/rs1/rs2/rd fields plus a sign-extended immediate.
- Presents the result to the buffer's id_* interface.
- Holds a registered output stage plus a one-entry skid register, so fetch-side ready is a flop and no word is lost under buffer backpressure.

Parameters:
- DATA_WIDTH, 32, immediate width presented to the buffer; must be >= 32. The immediate is sign-extended from bit 31 of the instruction to DATA_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- flush  input  1  synchronous discard of all held and incoming instructions.
- if_valid  input  1  fetch presents if_inst.
- if_inst  input  32  raw instruction word.
- if_ready  output  1  decode can accept this cycle (registered).
- id_valid  output  1  decoded instruction presented to the buffer.
- ib_vacant  input  1  buffer accepts this cycle; connects to the buffer's id_vacant.
- id_opt  output  7  inst[6:0].
- id_funct  output  3  inst[14:12], or 0 for U/J formats.
- id_rs1  output  5  inst[19:15], or 0 when the format has no rs1.
- id_rs2  output  5  inst[24:20], or 0 when the format has no rs2.
- id_rd  output  5  inst[11:7], or 0 for S/B formats.
- id_imm  output  DATA_WIDTH  format-specific sign-extended immediate.
- err_illegal  output  1  sticky flag: an unsupported opcode was dropped.

Behaviour:
- Reset (async, rst=1): main and skid entries invalid, id_valid=0, all id_* fields 0, if_ready=1, err_illegal=0.
  - Reset mid-transfer discards both entries with no partial output.
- Handshakes:
  - Fetch transfer when if_valid && if_ready.
  - Output transfer when id_valid && ib_vacant.
  - id_* fields stay stable while id_valid=1 and ib_vacant=0.
- Latency: an instruction accepted at edge N appears with id_valid=1 after edge N, provided the main entry is empty or transferring out.
- Formats by opt:
  - R (0110011): imm=0.
  - I (0010011, 0000011, 1100111): imm=sext(inst[31:20]); rs2=0.
  - S (0100011): imm=sext({inst[31:25],inst[11:7]}); rd=0.
  - B (1100011): imm=sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); rd=0.
  - U (0110111, 0010111): imm={inst[31:12],12'b0}; rs1=rs2=0; funct=0.
  - J (1101111): imm=sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); rs1=rs2=0; funct=0.
- Illegal opcode (any other opt):
  - Word is accepted (if_ready honoured) but never stored.
  - err_illegal is set and stays 1 until reset.
- Storage moves, per clock:
  - If main is empty or transferring out: skid (if valid) moves to main, else the accepted word goes to main.
  - If skid moves to main and a word is accepted the same cycle, the accepted word goes to skid.
  - If main is held: the accepted word goes to skid.
- Back-pressure:
  - if_ready next = !(skid valid next).
  - Program order is preserved in all cases.
- Full: main and skid both valid → if_ready=0; fetch must hold if_inst.
- Simultaneous output transfer and accept with skid empty: main is replaced by the new word; id_valid stays 1 with no bubble.
- Flush:
  - Has priority over every transfer in the same cycle; both entries are invalidated and the incoming word is dropped.
  - Next cycle id_valid=0 and if_ready=1.
  - err_illegal is unaffected.

Decomposition:
- Shared package rv_pkg (also used by i_buffer): OPT_SIZE=7, FUNCT_SIZE=3, REG_SIZE=5, opcode constants OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL.
- One combinational sub-module, i_decode_fields: inst → fields/imm/illegal. The top holds only the main/skid registers and handshake logic.

Test Plan:
- addi x1,x2,-5 (0xFFB10093), ib_vacant=1 → one cycle later: id_opt=0010011, funct=0, rs1=2, rs2=0, rd=1, imm=0xFFFFFFFB.
- sw x5,8(x6) (0x00532423) → id_opt=0100011, funct=2, rs1=6, rs2=5, rd=0, imm=8.
- lui x3,0x12345 (0x123451B7) → imm=0x12345000, rd=3, rs1=rs2=funct=0.
- beq x0,x0,-4 (0xFE000EE3) → imm=0xFFFFFFFC, rd=0.
- Backpressure:
  - Stimulus: ib_vacant=0; fetch offers 0xFFB10093, 0x00532423, 0x123451B7 back-to-back.
  - Expected: the first two are accepted, if_ready=0 from the cycle after the second, the third is held.
  - Then raise ib_vacant: outputs appear in order on three consecutive cycles with no loss or duplication.
- Illegal and flush:
  - 0x00000000 → no id_valid and err_illegal=1.
  - Flush with both entries full → id_valid=0 and if_ready=1 next cycle; err_illegal still 1; rst clears it asynchronously.
